// File: rtl/mem_access_stage.sv
// Memory stage: load/store over a req/ack data port with timeout, stalling upstream while busy.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with mem_err.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_mem,
  input  logic [DATA_W-1:0] insn,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_insn,
  output logic              mem_err
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [7:0] LIMIT  = 8'(MAX_WAIT - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wbv_q, wbv_d;
  logic [31:0] wbd_q, wbd_d;
  logic [31:0] wbi_q, wbi_d;
  logic        err_q, err_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] ins_q, ins_d;

  logic [5:0]  opc;
  logic [1:0]  off;
  logic        is_ld, is_st, is_mem, is_b, is_h;
  logic        misal, issue;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sx;
  logic [31:0] ld_val;

  assign opc = insn[31:26];
  assign off = alu_result[1:0];

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    case (opc)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_ld = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_st = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;
  assign is_b   = opc[1:0] == 2'b00;
  assign is_h   = opc[1:0] == 2'b01;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = is_mem &&
                 ((is_h && off[0]) || (!is_b && !is_h && off != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign issue = valid_mem && is_mem && !misal;

  // Lane 0 is the most significant byte.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = rt_data;
    if (is_b) begin
      be_n    = 4'b1000 >> off;
      wdata_n = {4{rt_data[7:0]}};
    end else if (is_h) begin
      be_n    = off[1] ? 4'b0011 : 4'b1100;
      wdata_n = {2{rt_data[15:0]}};
    end
  end

  always_comb begin
    unique case (off_q)
      2'd0: lb = mem_rdata[31:24];
      2'd1: lb = mem_rdata[23:16];
      2'd2: lb = mem_rdata[15:8];
      2'd3: lb = mem_rdata[7:0];
    endcase
    lh = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    sx = !op_q[2];
    unique case (op_q[1:0])
      2'b00:   ld_val = {{24{sx & lb[7]}}, lb};
      2'b01:   ld_val = {{16{sx & lh[15]}}, lh};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbi_d   = wbi_q;
    err_d   = 1'b0;
    op_d    = op_q;
    off_d   = off_q;
    ins_d   = ins_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {alu_result[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          op_d    = opc;
          off_d   = off;
          ins_d   = insn;
        end else if (valid_mem && misal) begin
          err_d = 1'b1;
        end else if (valid_mem) begin
          wbv_d = 1'b1;
          wbd_d = alu_result;
          wbi_d = insn;
        end
      end
      ACCESS: begin
        stall = !mem_ack;
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbi_d   = ins_q;
          wbd_d   = we_q ? 32'd0 : ld_val;
        end else if (cnt_q == LIMIT) begin
          // Ack in the limit cycle still completes normally above.
          state_d = IDLE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      wbv_q   <= 1'b0;
      wbd_q   <= 32'd0;
      wbi_q   <= 32'd0;
      err_q   <= 1'b0;
      op_q    <= 6'd0;
      off_q   <= 2'd0;
      ins_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbi_q   <= wbi_d;
      err_q   <= err_d;
      op_q    <= op_d;
      off_q   <= off_d;
      ins_q   <= ins_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wbv_q;
  assign wb_data   = wbd_q;
  assign wb_insn   = wbi_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, hand sequences, random ops vs reference model.
module tb_mem_access_stage;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset, valid_mem, mem_ack;
  logic [31:0] insn, alu_result, rt_data, mem_rdata;
  logic        stall, mem_req, mem_we, wb_valid, mem_err;
  logic [31:0] mem_addr, mem_wdata, wb_data, wb_insn;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAXW), .DATA_W(32)) dut (
    .clock(clk), .reset(reset), .valid_mem(valid_mem),
    .insn(insn), .alu_result(alu_result), .rt_data(rt_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_insn(wb_insn),
    .mem_err(mem_err)
  );

  typedef struct {
    logic [31:0] insn, addr, rt, rd;
    int          ack;
    bit          mem, mis, we, chkw;
    logic [3:0]  be;
    logic [31:0] eaddr, wdata, wb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, a, rt, rd,
                              input int ack, input bit mem, mis, we,
                              input logic [3:0] be,
                              input logic [31:0] ea, wd, wb);
    vec_t v;
    v.insn = i; v.addr = a; v.rt = rt; v.rd = rd; v.ack = ack;
    v.mem = mem; v.mis = mis; v.we = we; v.chkw = we;
    v.be = be; v.eaddr = ea; v.wdata = wd; v.wb = wb;
    return v;
  endfunction

  // Reference: sizes in bytes, lane index counted from the MSB byte.
  function automatic vec_t model(input logic [31:0] i, a, rt, rd,
                                 input int ack);
    vec_t v;
    int size, idx;
    bit sgn;
    longint val;
    v.insn = i; v.addr = a; v.rt = rt; v.rd = rd; v.ack = ack;
    v.mem = 1; v.we = 0; sgn = 0; size = 4;
    case (i[31:26])
      6'b100000: begin size = 1; sgn = 1; end
      6'b100001: begin size = 2; sgn = 1; end
      6'b100011: size = 4;
      6'b100100: size = 1;
      6'b100101: size = 2;
      6'b101000: begin size = 1; v.we = 1; end
      6'b101001: begin size = 2; v.we = 1; end
      6'b101011: begin size = 4; v.we = 1; end
      default: v.mem = 0;
    endcase
    v.chkw = v.we;
    idx = (size == 1) ? int'(a % 4) : (size == 2) ? int'(a % 4) / 2 * 2 : 0;
    v.mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    v.mis = v.mem && (int'(a % 4) % size != 0);
`endif
    v.eaddr = a - (a % 4);
    v.be = 4'b0;
    for (int k = 0; k < size; k++) v.be[3 - (idx + k)] = 1'b1;
    v.wdata = 32'd0;
    for (int b = 0; b < 4; b++)
      v.wdata[8*(3-b) +: 8] = 8'((rt >> (8 * ((size - 1) - (b % size)))) & 32'hFF);
    if (!v.mem) v.wb = a;
    else if (v.we) v.wb = 32'd0;
    else begin
      val = longint'(rd >> (8 * (4 - idx - size)));
      if (size < 4) begin
        val = val % (64'd1 << (8 * size));
        if (sgn && val >= (64'd1 << (8 * size - 1)))
          val = val - (64'd1 << (8 * size));
      end
      v.wb = 32'(val);
    end
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    bit done;
    @(negedge clk);
    valid_mem = 1; insn = v.insn; alu_result = v.addr;
    rt_data = v.rt; mem_ack = 0; mem_rdata = 32'd0;
    #1;
    chk({tag, ".stall_accept"}, 32'(stall), 32'(v.mem && !v.mis));
    if (!v.mem || v.mis) begin
      @(negedge clk);
      valid_mem = 0;
      #1;
      chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".mem_err"}, 32'(mem_err), 32'(v.mis));
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(!v.mis));
      if (!v.mis) begin
        chk({tag, ".wb_data"}, wb_data, v.wb);
        chk({tag, ".wb_insn"}, wb_insn, v.insn);
      end
      chk({tag, ".stall_after"}, 32'(stall), 32'd0);
      return;
    end
    done = 0;
    for (int k = 0; k < MAXW && !done; k++) begin
      @(negedge clk);
      chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, ".mem_addr"}, mem_addr, v.eaddr);
      if (k == 0) begin
        chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.be));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
        chk({tag, ".wb_valid_busy"}, 32'(wb_valid), 32'd0);
        if (v.chkw) chk({tag, ".mem_wdata"}, mem_wdata, v.wdata);
      end
      if (k == v.ack) begin
        mem_ack = 1; mem_rdata = v.rd;
        #1;
        chk({tag, ".stall_ack"}, 32'(stall), 32'd0);
        @(negedge clk);
        mem_ack = 0; valid_mem = 0;
        #1;
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_data"}, wb_data, v.wb);
        chk({tag, ".wb_insn"}, wb_insn, v.insn);
        chk({tag, ".mem_req_done"}, 32'(mem_req), 32'd0);
        chk({tag, ".mem_err_done"}, 32'(mem_err), 32'd0);
        done = 1;
      end else begin
        #1;
        chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
      end
    end
    if (!done) begin
      @(negedge clk);
      valid_mem = 0;
      #1;
      chk({tag, ".to_err"}, 32'(mem_err), 32'd1);
      chk({tag, ".to_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".to_wbv"}, 32'(wb_valid), 32'd0);
      chk({tag, ".to_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      #1;
      chk({tag, ".to_err_pulse"}, 32'(mem_err), 32'd0);
    end
  endtask

  vec_t tbl[10];
  logic [5:0] ops[10] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                         6'b100101, 6'b101000, 6'b101001, 6'b101011,
                         6'b000000, 6'b001000};

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(32'h00851020, 32'h2A, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h2A);
    tbl[1] = mk(32'h8C000000, 32'h104, 0, 32'hDEADBEEF, 3, 1, 0, 0,
                4'b1111, 32'h104, 0, 32'hDEADBEEF);
    tbl[2] = mk(32'h80000000, 32'h203, 0, 32'h11223380, 0, 1, 0, 0,
                4'b0001, 32'h200, 0, 32'hFFFFFF80);
    tbl[3] = mk(32'h90000000, 32'h203, 0, 32'h11223380, 1, 1, 0, 0,
                4'b0001, 32'h200, 0, 32'h00000080);
    tbl[4] = mk(32'h84000000, 32'h202, 0, 32'h1122F00D, 1, 1, 0, 0,
                4'b0011, 32'h200, 0, 32'hFFFFF00D);
    tbl[5] = mk(32'hA0000000, 32'h10, 32'hA5, 0, 0, 1, 0, 1,
                4'b1000, 32'h10, 32'hA5A5A5A5, 0);
    tbl[6] = mk(32'hA4000000, 32'h12, 32'h1234, 0, 2, 1, 0, 1,
                4'b0011, 32'h10, 32'h12341234, 0);
    tbl[7] = mk(32'hAC000000, 32'h20, 32'h12345678, 0, 99, 1, 0, 1,
                4'b1111, 32'h20, 32'h12345678, 0);
`ifdef MEM_ALIGN_CHECK_EN
    tbl[8] = mk(32'h8C000000, 32'h102, 0, 32'hCAFEF00D, 0, 1, 1, 0,
                4'b1111, 32'h100, 0, 0);
`else
    tbl[8] = mk(32'h8C000000, 32'h102, 0, 32'hCAFEF00D, 0, 1, 0, 0,
                4'b1111, 32'h100, 0, 32'hCAFEF00D);
`endif
    tbl[9] = mk(32'h94000000, 32'h300, 0, 32'h80010002, 0, 1, 0, 0,
                4'b1100, 32'h300, 0, 32'h00008001);

    reset = 1; valid_mem = 0; mem_ack = 0;
    insn = 0; alu_result = 0; rt_data = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_be", 32'(mem_be), 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.wb_valid", 32'(wb_valid), 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wb_insn", wb_insn, 0);
    chk("rst.mem_err", 32'(mem_err), 0);

    for (int i = 0; i < 10; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while an access is outstanding.
    @(negedge clk);
    valid_mem = 1; insn = 32'hAC000000; alu_result = 32'h40;
    rt_data = 32'h55; mem_ack = 0;
    @(negedge clk);
    chk("rstmid.req", 32'(mem_req), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; valid_mem = 0;
    #1;
    chk("rstmid.req_drop", 32'(mem_req), 0);
    chk("rstmid.err", 32'(mem_err), 0);
    chk("rstmid.wbv", 32'(wb_valid), 0);
    chk("rstmid.stall", 32'(stall), 0);
    @(negedge clk);
    #1;
    chk("rstmid.err2", 32'(mem_err), 0);
    chk("rstmid.wbv2", 32'(wb_valid), 0);

    // Idle cycle clears wb_valid.
    do_op(tbl[0], "pre_idle");
    @(negedge clk);
    #1;
    chk("idle.wbv", 32'(wb_valid), 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ri, ra;
      ri = {ops[$urandom_range(0, 9)], 26'($urandom)};
      ra = $urandom;
      do_op(model(ri, ra, $urandom, $urandom, $urandom_range(0, 5)),
            $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
